box_plotter: RTL and testbench
==============================

# box_plotter

Pixel-drawing engine for the SpyMangler display path. It takes one box request and emits one pixel write per clock to the VGA adapter. A request is a top-left coordinate, a 3-bit colour and a full/outline flag, in the same form the code-entry translator produces. Each accepted request draws a BOX_W × BOX_H rectangle in raster order. The block then pulses `done` and returns to idle for the next request.

## Interface
Parameters:
- `BOX_W`, 8: box width in pixels (1..16).
- `BOX_H`, 3: box height in pixels (1..16).

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `X`  in  8  top-left x of the box.
- `Y`  in  8  top-left y of the box.
- `colour`  in  3  box colour.
- `draw_full`  in  1  1 = filled box; 0 = outline only.
- `vga_x`  out  8  pixel x to the adapter.
- `vga_y`  out  8  pixel y to the adapter.
- `vga_colour`  out  3  pixel colour to the adapter.
- `plot`  out  1  adapter write enable for the current pixel.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse after the last pixel.

## Operation
- States:
  - IDLE → DRAW when `start`=1; this is the only accepting state.
  - DRAW → DRAW while pixels remain.
  - DRAW → DONE after pixel (BOX_W-1, BOX_H-1).
  - DONE → IDLE unconditionally.
- Request latch:
  - On acceptance, `X`, `Y`, `colour` and `draw_full` are copied into internal registers.
  - Input changes after acceptance do not affect the box in progress.
- Pixel counters:
  - `cx` runs 0..BOX_W-1 and `cy` runs 0..BOX_H-1, raster order (`cx` fastest).
  - `cx` wraps to 0 and `cy` increments when `cx`=BOX_W-1.
- Each DRAW cycle drives these registered outputs:
  - `vga_x` = latched X + `cx`, `vga_y` = latched Y + `cy`, both truncated to 8 bits (wrap modulo 256, no saturation).
  - `vga_colour` = latched colour.
  - `plot` = 1 if `draw_full`=1. If `draw_full`=0, `plot`=1 only when `cx`∈{0, BOX_W-1} or `cy`∈{0, BOX_H-1}.
  - Interior pixels of an outline box still take their cycle, with `plot`=0.
- `start` during DRAW or DONE is ignored and is not queued.
- Outputs while not in DRAW:
  - `plot`=0.
  - `vga_x`, `vga_y` and `vga_colour` hold their last values.

## Timing
- Reset values: `vga_x`=0, `vga_y`=0, `vga_colour`=0, `plot`=0, `busy`=0, `done`=0, state IDLE, counters 0, latches 0.
- Cycle numbering: the edge that samples `start`=1 in IDLE is edge 0.
- Pixel (0,0) is presented after edge 1, with `busy`=1 from edge 1.
- Pixel k (0-based raster index) is presented after edge k+1.
- The last pixel is presented after edge BOX_W·BOX_H.
- `done`=1 after edge BOX_W·BOX_H+1 for exactly one cycle; `busy` stays 1 during DONE.
- State is IDLE after edge BOX_W·BOX_H+2. A new `start` sampled at that edge begins the next box with no further gap.
- Total occupancy per box: BOX_W·BOX_H+2 cycles (26 with the defaults).
- `start` held high continuously: one box per 26 cycles; the request is re-latched each time IDLE is reached.
- Reset asserted mid-draw:
  - Immediately forces the reset values (`plot` drops without waiting for a clock).
  - The partial box is abandoned and no `done` is issued.
- Degenerate sizes (BOX_W=1 or BOX_H=1): every pixel is a border pixel, so `plot`=1 for all pixels regardless of `draw_full`.

## Structure
- Shared package `spy_pkg` holds:
  - State enum: IDLE, DRAW, DONE.
  - Default box constants (BOX_W=8, BOX_H=3).
  - Translator geometry constants: column pitch 10, row pitch 4, origin (20,30).
- One sub-module, `raster_counter`:
  - Parameterised by width and height.
  - Outputs `cx` and `cy`, plus a `last` flag high at (W-1,H-1).
  - Synchronous clear on accept, increment enable in DRAW.
- The top level holds the FSM, the request latch, the border compare and the output registers.

## Test plan
- Reset release: all outputs 0 and `busy`=0.
  - `start`=1 with X=20, Y=30, colour=3'b100, `draw_full`=1 → 24 consecutive plots.
  - First plot at (20,30), last plot at (27,32); `done` 25 cycles after the last plot? No: `done` one cycle after the last plot, i.e. after edge 25.
- Outline box: X=30, Y=34, colour=3'b111, `draw_full`=0 → 18 plots and 6 skips.
  - Skipped pixels are x=31..36 at y=35.
  - `done` after edge 25.
- Wrap-around: X=252, Y=254, `draw_full`=1.
  - `vga_x` runs 252..255 then 0..3.
  - `vga_y` runs 254, 255, 0.
- `start` pulses at edges 5 and 25 of an active box: both ignored, and exactly one `done` is seen.
- With `start` held high, the next box's first pixel appears after edge 27.
- Reset at edge 10 of a box: `plot` falls asynchronously before the next clock.
  - No `done` follows.
  - A `start` after reset release draws a complete new box from pixel (0,0).

Source files
------------

// File: rtl/spy_pkg.sv
// Shared definitions for the SpyMangler display path: the box plotter
// state encoding, default box geometry and the code-entry translator
// layout constants that requests are built from.
package spy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } plot_state_t;

    // Default box size in pixels.
    localparam int BOX_W_DEF = 8;
    localparam int BOX_H_DEF = 3;

    // Pixel counters must hold 0..15 (boxes are at most 16 pixels a side).
    localparam int CNT_W = 4;

    // Translator grid: where code-entry cells land on screen.
    localparam int COL_PITCH = 10;
    localparam int ROW_PITCH = 4;
    localparam int ORIGIN_X  = 20;
    localparam int ORIGIN_Y  = 30;

    // A pixel is on the border if it sits on the first/last column or row.
    // With a one-pixel-wide or one-pixel-high box every pixel qualifies.
    function automatic logic is_border(
        input logic [CNT_W-1:0] cx,
        input logic [CNT_W-1:0] cy,
        input logic [CNT_W-1:0] last_x,
        input logic [CNT_W-1:0] last_y
    );
        return (cx == '0) || (cx == last_x) || (cy == '0) || (cy == last_y);
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order pixel counter: cx runs fastest, cy advances when cx wraps.
// o_last flags the final pixel so the controller can leave the draw state.
module raster_counter
    import spy_pkg::*;
#(
    parameter int W = BOX_W_DEF,
    parameter int H = BOX_H_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cx,
    output logic [CNT_W-1:0] o_cy,
    output logic             o_last
);

    localparam logic [CNT_W-1:0] X_MAX = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] Y_MAX = CNT_W'(H - 1);

    logic [CNT_W-1:0] r_cx;
    logic [CNT_W-1:0] r_cy;

    // Clear on a new request, otherwise step through the box in raster order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (i_clr) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (i_en) begin
            if (r_cx == X_MAX) begin
                r_cx <= '0;
                r_cy <= (r_cy == Y_MAX) ? '0 : r_cy + CNT_W'(1);
            end else begin
                r_cx <= r_cx + CNT_W'(1);
            end
        end
    end

    assign o_cx   = r_cx;
    assign o_cy   = r_cy;
    assign o_last = (r_cx == X_MAX) && (r_cy == Y_MAX);

endmodule

// File: rtl/box_plotter.sv
// Box plotter: accepts one box request, emits one pixel write per clock in
// raster order, then pulses done for a cycle before accepting again.
//
// state | meaning
// IDLE  | waiting for start; the only state that accepts a request
// DRAW  | one pixel per cycle from the raster counter
// DONE  | all pixels issued; done pulses on the following edge
module box_plotter
    import spy_pkg::*;
#(
    parameter int BOX_W = BOX_W_DEF,
    parameter int BOX_H = BOX_H_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] X,
    input  logic [7:0] Y,
    input  logic [2:0] colour,
    input  logic       draw_full,
    output logic [7:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(BOX_W - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(BOX_H - 1);

    plot_state_t      r_state;
    plot_state_t      w_state_next;
    logic             w_accept;

    logic [7:0]       r_x;
    logic [7:0]       r_y;
    logic [2:0]       r_colour;
    logic             r_full;

    logic [CNT_W-1:0] w_cx;
    logic [CNT_W-1:0] w_cy;
    logic             w_last;
    logic             w_drawing;
    logic             w_border;

    logic [7:0]       r_vga_x;
    logic [7:0]       r_vga_y;
    logic [2:0]       r_vga_colour;
    logic             r_plot;
    logic             r_busy;
    logic             r_done;

    assign w_drawing = (r_state == ST_DRAW);
    assign w_border  = is_border(w_cx, w_cy, X_LAST, Y_LAST);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a request is only taken while idle.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_DRAW;
                    w_accept     = 1'b1;
                end
            end
            ST_DRAW: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Capture the request so input changes mid-box have no effect.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_full   <= 1'b0;
        end else if (w_accept) begin
            r_x      <= X;
            r_y      <= Y;
            r_colour <= colour;
            r_full   <= draw_full;
        end
    end

    raster_counter #(
        .W (BOX_W),
        .H (BOX_H)
    ) u_raster_counter (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_clr   (w_accept),
        .i_en    (w_drawing),
        .o_cx    (w_cx),
        .o_cy    (w_cy),
        .o_last  (w_last)
    );

    // Pixel outputs: coordinates wrap modulo 256; they hold outside DRAW
    // while plot is forced low, so the adapter never sees a stray write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_plot       <= 1'b0;
        end else if (w_drawing) begin
            r_vga_x      <= r_x + 8'(w_cx);
            r_vga_y      <= r_y + 8'(w_cy);
            r_vga_colour <= r_colour;
            r_plot       <= r_full | w_border;
        end else begin
            r_plot       <= 1'b0;
        end
    end

    // Status flags are registered so they line up with the pixel outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (r_state != ST_IDLE);
            r_done <= (r_state == ST_DONE);
        end
    end

    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_colour;
    assign plot       = r_plot;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_box_plotter.sv
// Bench for box_plotter: directed and random box requests compared against
// a per-pixel reference computed directly from the box geometry.
module tb_box_plotter;

    localparam int W = 8;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] X;
    logic [7:0] Y;
    logic [2:0] colour;
    logic       draw_full;
    logic [7:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    box_plotter #(.BOX_W(W), .BOX_H(H)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .X          (X),
        .Y          (Y),
        .colour     (colour),
        .draw_full  (draw_full),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: which pixels of a box get written.
    function automatic bit ref_plot(input int cx, input int cy, input bit full);
        return full || cx == 0 || cx == W - 1 || cy == 0 || cy == H - 1;
    endfunction

    function automatic int ref_plot_count(input bit full);
        int iw, ih;
        iw = (W > 2) ? W - 2 : 0;
        ih = (H > 2) ? H - 2 : 0;
        return full ? N : N - iw * ih;
    endfunction

    // Draws one box starting from the sample point just before edge 0.
    // hold keeps start high throughout; pulse drives stray starts at edge 5
    // and edge N+1; abort_at > 0 asserts reset after that edge and returns.
    task automatic run_box(input logic [7:0] bx, input logic [7:0] by, input logic [2:0] bc,
                           input bit full, input bit hold, input bit pulse, input int abort_at);
        int plots;
        int cx, cy;
        plots     = 0;
        X         = bx;
        Y         = by;
        colour    = bc;
        draw_full = full;
        start     = 1'b1;
        @(posedge clock); #1;
        start     = hold;
        X         = 8'($urandom);
        Y         = 8'($urandom);
        colour    = 3'($urandom);
        draw_full = 1'($urandom);
        for (int k = 1; k <= N; k++) begin
            @(posedge clock); #1;
            cx = (k - 1) % W;
            cy = (k - 1) / W;
            check_val("pix_x",   vga_x,      (bx + cx) % 256);
            check_val("pix_y",   vga_y,      (by + cy) % 256);
            check_val("pix_col", vga_colour, bc);
            check_val("pix_plot", plot,      ref_plot(cx, cy, full));
            check_val("pix_busy", busy,      1);
            check_val("pix_done", done,      0);
            if (plot === 1'b1) plots++;
            if (k == abort_at) begin
                #2 reset = 1'b0;
                #1;
                check_val("rst_plot",  plot,  0);
                check_val("rst_x",     vga_x, 0);
                check_val("rst_busy",  busy,  0);
                start = 1'b0;
                return;
            end
            start = hold | (pulse && (k + 1 == 5 || k + 1 == N + 1));
        end
        check_val("plot_count", plots, ref_plot_count(full));
        @(posedge clock); #1;
        check_val("done_pulse", done,  1);
        check_val("done_busy",  busy,  1);
        check_val("done_plot",  plot,  0);
        check_val("hold_x",     vga_x, (bx + W - 1) % 256);
        check_val("hold_y",     vga_y, (by + H - 1) % 256);
        start = hold;
    endtask

    // After a non-held box: done must clear and no ignored start may launch a box.
    task automatic check_idle_after;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check_val("idle_done", done, 0);
            check_val("idle_plot", plot, 0);
            if (i > 0) check_val("idle_busy", busy, 0);
        end
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        X         = '0;
        Y         = '0;
        colour    = '0;
        draw_full = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_vga_x", vga_x, 0);
        check_val("rst_vga_y", vga_y, 0);
        check_val("rst_col",   vga_colour, 0);
        check_val("rst_plot0", plot, 0);
        check_val("rst_busy0", busy, 0);
        check_val("rst_done0", done, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        check_val("rel_plot", plot, 0);
        check_val("rel_busy", busy, 0);
        check_val("rel_done", done, 0);

        run_box(8'd20, 8'd30, 3'b100, 1'b1, 1'b0, 1'b0, 0);
        check_idle_after();

        run_box(8'd30, 8'd34, 3'b111, 1'b0, 1'b0, 1'b0, 0);
        check_idle_after();

        run_box(8'd252, 8'd254, 3'b010, 1'b1, 1'b0, 1'b0, 0);
        check_idle_after();

        run_box(8'd100, 8'd50, 3'b001, 1'b0, 1'b0, 1'b1, 0);
        check_idle_after();

        // start held high: boxes follow each other with a 26-cycle period.
        run_box(8'd40, 8'd60, 3'b011, 1'b1, 1'b1, 1'b0, 0);
        run_box(8'd70, 8'd80, 3'b101, 1'b0, 1'b1, 1'b0, 0);
        start = 1'b0;
        check_idle_after();

        // Reset in the middle of a box: no done, then a clean new box.
        run_box(8'd5, 8'd6, 3'b110, 1'b1, 1'b0, 1'b0, 10);
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        for (int i = 0; i < N + 4; i++) begin
            @(posedge clock); #1;
            check_val("abort_done", done, 0);
            check_val("abort_plot", plot, 0);
        end
        run_box(8'd5, 8'd6, 3'b110, 1'b0, 1'b0, 1'b0, 0);
        check_idle_after();

        for (int r = 0; r < 8; r++) begin
            run_box(8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom),
                    1'b0, 1'($urandom), 0);
            check_idle_after();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
